// File: rtl/diff_commit_pkg.sv
`default_nettype none
// ============================================================================
// diff_commit_pkg : commit/exception record types for diff_commit_queue
// Optional macro DIFF_COMMIT_TIMER_EN adds is_CNTinst/timer_64_value storage
// Revision: 1.0
// ============================================================================
package diff_commit_pkg;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        skip;
    logic        is_TLBFILL;
    logic [4:0]  TLBFILL_index;
`ifdef DIFF_COMMIT_TIMER_EN
    logic        is_CNTinst;
    logic [63:0] timer_64_value;
`endif
    logic        wen;
    logic [7:0]  wdest;
    logic [63:0] wdata;
    logic        csr_rstat;
    logic [31:0] csr_data;
  } commit_rec_t;

  // Emitted form always carries the timer fields, whether or not they are stored
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        skip;
    logic        is_TLBFILL;
    logic [4:0]  TLBFILL_index;
    logic        is_CNTinst;
    logic [63:0] timer_64_value;
    logic        wen;
    logic [7:0]  wdest;
    logic [63:0] wdata;
    logic        csr_rstat;
    logic [31:0] csr_data;
  } commit_out_t;

  typedef struct packed {
    logic        eret;
    logic [10:0] intrNo;
    logic [5:0]  cause;
    logic [31:0] pc;
    logic [31:0] inst;
  } excp_rec_t;

  localparam int REC_W  = $bits(commit_rec_t);
  localparam int EXCP_W = $bits(excp_rec_t);

  typedef enum logic [0:0] {
    EXCP_IDLE = 1'b0,
    EXCP_PEND = 1'b1
  } excp_state_t;

  function automatic commit_out_t to_out(input commit_rec_t r);
    commit_out_t o;
    o.pc             = r.pc;
    o.instr          = r.instr;
    o.skip           = r.skip;
    o.is_TLBFILL     = r.is_TLBFILL;
    o.TLBFILL_index  = r.TLBFILL_index;
`ifdef DIFF_COMMIT_TIMER_EN
    o.is_CNTinst     = r.is_CNTinst;
    o.timer_64_value = r.timer_64_value;
`else
    o.is_CNTinst     = 1'b0;
    o.timer_64_value = 64'd0;
`endif
    o.wen            = r.wen;
    o.wdest          = r.wdest;
    o.wdata          = r.wdata;
    o.csr_rstat      = r.csr_rstat;
    o.csr_data       = r.csr_data;
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/diff_commit_queue_if.sv
`default_nettype none
// ============================================================================
// diff_commit_queue_if : commit-stage to difftest bundle for diff_commit_queue
// Revision: 1.0
// ============================================================================
interface diff_commit_queue_if #(
  parameter int NCOMMIT = 3,
  parameter int NOUT    = 2
);
  import diff_commit_pkg::*;

  logic [7:0]                 coreid;
  logic [7:0]                 out_coreid;
  logic [NCOMMIT-1:0]         in_valid;
  commit_rec_t [NCOMMIT-1:0]  in_rec;
  logic                       in_ready;
  logic                       excp_in_valid;
  excp_rec_t                  excp_in;
  logic [NOUT-1:0]            out_valid;
  logic [NOUT-1:0][7:0]       out_index;
  commit_out_t [NOUT-1:0]     out_rec;
  logic                       excp_out_valid;
  excp_rec_t                  excp_out;
  logic [63:0]                commit_cnt;
  logic                       overflow;

  modport master (
    output coreid, in_valid, in_rec, excp_in_valid, excp_in,
    input  out_coreid, in_ready, out_valid, out_index, out_rec,
           excp_out_valid, excp_out, commit_cnt, overflow
  );

  modport slave (
    input  coreid, in_valid, in_rec, excp_in_valid, excp_in,
    output out_coreid, in_ready, out_valid, out_index, out_rec,
           excp_out_valid, excp_out, commit_cnt, overflow
  );

endinterface
`default_nettype wire

// File: rtl/diff_lane_compact.sv
`default_nettype none
// ============================================================================
// diff_lane_compact : prefix-sum packing of sparse lanes into a dense vector
// Revision: 1.0
// ============================================================================
module diff_lane_compact #(
  parameter int NCOMMIT = 3,
  parameter int W       = 8,
  parameter int PW      = $clog2(NCOMMIT + 1)
) (
  input  logic [NCOMMIT-1:0]        valid,
  input  logic [NCOMMIT-1:0][W-1:0] lanes,
  output logic [NCOMMIT-1:0][W-1:0] dense,
  output logic [PW-1:0]             cnt
);

  logic [NCOMMIT-1:0][PW-1:0] w_pre;
  logic [PW-1:0]              w_acc;

  // w_pre[i] is the dense slot lane i lands in: number of valid lanes below it
  always_comb begin
    w_pre = '0;
    w_acc = '0;
    for (int i = 0; i < NCOMMIT; i++) begin
      w_pre[i] = w_acc;
      w_acc    = w_acc + PW'(valid[i]);
    end
  end

  assign cnt = w_acc;

  always_comb begin
    dense = '0;
    for (int j = 0; j < NCOMMIT; j++) begin
      for (int i = 0; i < NCOMMIT; i++) begin
        if (valid[i] && (w_pre[i] == PW'(j))) begin
          dense[j] = lanes[i];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/diff_commit_queue.sv
`default_nettype none
// ============================================================================
// diff_commit_queue : compacting commit FIFO feeding NOUT difftest slots,
// holding exception events behind older commits. Macro: DIFF_COMMIT_TIMER_EN
// Revision: 1.0
// ============================================================================
module diff_commit_queue
  import diff_commit_pkg::*;
#(
  parameter int NCOMMIT = 3,
  parameter int NOUT    = 2,
  parameter int DEPTH   = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  diff_commit_queue_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(NCOMMIT + 1);

  excp_state_t               r_state, w_state_nxt;
  logic [AW-1:0]             r_head, r_tail;
  logic [CW-1:0]             r_count, r_remain, w_remain_nxt;
  logic [63:0]               r_commit_cnt;
  logic                      r_overflow;
  excp_rec_t                 r_excp;
  commit_rec_t               r_mem [DEPTH];

  commit_rec_t [NCOMMIT-1:0] w_dense;
  logic [PW-1:0]             w_lane_cnt;
  logic                      w_ready, w_capture, w_offer;
  logic [CW-1:0]             w_pushes, w_pops, w_count_nxt;
  logic [NOUT-1:0]           w_slot_valid;

  diff_lane_compact #(
    .NCOMMIT (NCOMMIT),
    .W       (REC_W),
    .PW      (PW)
  ) u_compact (
    .valid (bus.in_valid),
    .lanes (bus.in_rec),
    .dense (w_dense),
    .cnt   (w_lane_cnt)
  );

  assign w_ready     = ((CW'(DEPTH) - r_count) >= CW'(NCOMMIT)) && (r_state == EXCP_IDLE);
  assign w_offer     = (|bus.in_valid) || bus.excp_in_valid;
  assign w_pushes    = w_ready ? CW'(w_lane_cnt) : '0;
  assign w_pops      = (r_count > CW'(NOUT)) ? CW'(NOUT) : r_count;
  assign w_count_nxt = r_count + w_pushes - w_pops;

  // remain counts older records still queued after this edge, so the pulse
  // lands in the cycle that emits the last of them
  always_comb begin
    w_state_nxt        = r_state;
    w_remain_nxt       = r_remain;
    w_capture          = 1'b0;
    bus.excp_out_valid = 1'b0;
    case (r_state)
      EXCP_IDLE: begin
        if (bus.excp_in_valid && w_ready) begin
          w_capture    = 1'b1;
          w_remain_nxt = w_count_nxt;
          w_state_nxt  = EXCP_PEND;
        end
      end
      EXCP_PEND: begin
        if (r_remain <= CW'(NOUT)) begin
          bus.excp_out_valid = 1'b1;
          w_remain_nxt       = '0;
          w_state_nxt        = EXCP_IDLE;
        end else begin
          w_remain_nxt = r_remain - w_pops;
        end
      end
      default: w_state_nxt = EXCP_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= EXCP_IDLE;
      r_remain     <= '0;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_commit_cnt <= '0;
      r_overflow   <= 1'b0;
      r_excp       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_remain     <= w_remain_nxt;
      r_head       <= r_head + AW'(w_pops);
      r_tail       <= r_tail + AW'(w_pushes);
      r_count      <= w_count_nxt;
      r_commit_cnt <= r_commit_cnt + 64'(w_pops);
      if (w_capture) begin
        r_excp <= bus.excp_in;
      end
      if (!w_ready && w_offer) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int j = 0; j < NCOMMIT; j++) begin
      if (CW'(j) < w_pushes) begin
        r_mem[r_tail + AW'(j)] <= w_dense[j];
      end
    end
  end

  for (genvar i = 0; i < NOUT; i++) begin : g_slot
    assign w_slot_valid[i]  = CW'(i) < w_pops;
    assign bus.out_valid[i] = w_slot_valid[i];
    assign bus.out_index[i] = 8'(i);
    assign bus.out_rec[i]   = w_slot_valid[i] ? to_out(r_mem[r_head + AW'(i)]) : '0;
  end

  assign bus.in_ready   = w_ready;
  assign bus.out_coreid = bus.coreid;
  assign bus.excp_out   = r_excp;
  assign bus.commit_cnt = r_commit_cnt;
  assign bus.overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_diff_commit_queue.sv
`default_nettype none
// ============================================================================
// tb_diff_commit_queue : directed self-checking bench for diff_commit_queue
// Revision: 1.0
// ============================================================================
module tb_diff_commit_queue;
  import diff_commit_pkg::*;

  localparam int NCOMMIT = 3;
  localparam int NOUT    = 2;
  localparam int DEPTH   = 8;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] seen [$];
  int          excp_pulses  = 0;
  int          excp_seen_at = -1;
  excp_rec_t   ex;

  diff_commit_queue_if #(.NCOMMIT(NCOMMIT), .NOUT(NOUT)) bus ();

  diff_commit_queue #(
    .NCOMMIT (NCOMMIT),
    .NOUT    (NOUT),
    .DEPTH   (DEPTH)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  // Emission log, taken mid-cycle
  always @(negedge clock) begin
    if (reset_n) begin
      for (int i = 0; i < NOUT; i++) begin
        if (bus.out_valid[i]) seen.push_back(bus.out_rec[i].pc);
      end
      if (bus.excp_out_valid) begin
        excp_pulses++;
        excp_seen_at = seen.size();
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    n_checks++;
    if (got_v !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got_v, exp_v);
    end
  endtask

  function automatic commit_rec_t mk(input logic [63:0] pc);
    commit_rec_t r;
    r       = '0;
    r.pc    = pc;
    r.instr = pc[31:0] ^ 32'h0000_0013;
    r.wen   = 1'b1;
    r.wdata = ~pc;
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [NCOMMIT-1:0] v, input logic [63:0] base);
    for (int l = 0; l < NCOMMIT; l++) bus.in_rec[l] = mk(base + 64'(l));
    bus.in_valid = v;
  endtask

  task automatic idle();
    bus.in_valid      = '0;
    bus.excp_in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({pfx, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    check({pfx, "_excp_valid"}, 64'(bus.excp_out_valid), 64'd0);
    check({pfx, "_commit_cnt"}, bus.commit_cnt, 64'd0);
    check({pfx, "_overflow"}, 64'(bus.overflow), 64'd0);
  endtask

  initial begin
    int dead_found;
    bus.coreid        = 8'h5a;
    bus.in_valid      = '0;
    bus.in_rec        = '0;
    bus.excp_in_valid = 1'b0;
    bus.excp_in       = '0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("rst");
    reset_n = 1'b1;
    tick();
    check("coreid_pass", 64'(bus.out_coreid), 64'h5a);

    // Lane-order compaction: lanes 0 and 2 valid
    drive(3'b101, 64'h100);
    tick();
    idle();
    check("cmp_out_valid", 64'(bus.out_valid), 64'd3);
    check("cmp_slot0_pc", bus.out_rec[0].pc, 64'h100);
    check("cmp_slot1_pc", bus.out_rec[1].pc, 64'h102);
    check("cmp_slot1_wdata", bus.out_rec[1].wdata, ~64'h102);
    check("cmp_index0", 64'(bus.out_index[0]), 64'd0);
    check("cmp_index1", 64'(bus.out_index[1]), 64'd1);
    check("cmp_cnt_before", bus.commit_cnt, 64'd0);
    tick();
    check("cmp_cnt_after", bus.commit_cnt, 64'd2);
    check("cmp_drained", 64'(bus.out_valid), 64'd0);

    // Back-pressure: counts 0,3,4,5 accept; 6 stalls
    seen.delete();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("bp_ready_%0d", k), 64'(bus.in_ready), 64'd1);
      drive(3'b111, 64'h1000 + 64'(3 * k));
      tick();
    end
    idle();
    check("bp_ready_full", 64'(bus.in_ready), 64'd0);
    check("bp_no_overflow", 64'(bus.overflow), 64'd0);
    tick();
    check("bp_ready_again", 64'(bus.in_ready), 64'd1);
    tick();
    tick();
    check("bp_empty", 64'(bus.out_valid), 64'd0);
    check("bp_seen_count", 64'(seen.size()), 64'd12);
    for (int k = 0; k < 12; k++) begin
      if (k < seen.size()) check($sformatf("bp_order_%0d", k), seen[k], 64'h1000 + 64'(k));
    end
    check("bp_commit_cnt", bus.commit_cnt, 64'd14);

    // Exception behind 5 queued + 1 same-cycle commit
    seen.delete();
    excp_pulses = 0;
    for (int k = 0; k < 3; k++) begin
      drive(3'b111, 64'h2000 + 64'(3 * k));
      tick();
    end
    check("ex_ready_pre", 64'(bus.in_ready), 64'd1);
    drive(3'b001, 64'h2009);
    ex        = '0;
    ex.eret   = 1'b0;
    ex.intrNo = 11'h012;
    ex.cause  = 6'h08;
    ex.pc     = 32'h1c00_2000;
    ex.inst   = 32'h002b_0000;
    bus.excp_in       = ex;
    bus.excp_in_valid = 1'b1;
    tick();
    idle();
    check("ex_c4_ready", 64'(bus.in_ready), 64'd0);
    check("ex_c4_out_valid", 64'(bus.out_valid), 64'd3);
    check("ex_c4_excp", 64'(bus.excp_out_valid), 64'd0);
    tick();
    check("ex_c5_ready", 64'(bus.in_ready), 64'd0);
    check("ex_c5_out_valid", 64'(bus.out_valid), 64'd3);
    check("ex_c5_excp", 64'(bus.excp_out_valid), 64'd1);
    check("ex_c5_last_pc", bus.out_rec[1].pc, 64'h2009);
    check("ex_c5_excp_pc", 64'(bus.excp_out.pc), 64'h1c00_2000);
    tick();
    check("ex_c6_ready", 64'(bus.in_ready), 64'd1);
    check("ex_c6_excp", 64'(bus.excp_out_valid), 64'd0);
    check("ex_c6_out_valid", 64'(bus.out_valid), 64'd0);
    check("ex_pulses", 64'(excp_pulses), 64'd1);
    check("ex_pulse_after_n", 64'(excp_seen_at), 64'd10);
    check("ex_commit_cnt", bus.commit_cnt, 64'd24);

    // Exception on an empty queue
    excp_pulses = 0;
    ex          = '0;
    ex.eret     = 1'b1;
    ex.intrNo   = 11'h7ff;
    ex.cause    = 6'h0b;
    ex.pc       = 32'h1c00_0100;
    ex.inst     = 32'h0648_3800;
    check("ee_ready_pre", 64'(bus.in_ready), 64'd1);
    bus.excp_in       = ex;
    bus.excp_in_valid = 1'b1;
    tick();
    idle();
    check("ee_excp_valid", 64'(bus.excp_out_valid), 64'd1);
    check("ee_eret", 64'(bus.excp_out.eret), 64'd1);
    check("ee_cause", 64'(bus.excp_out.cause), 64'h0b);
    check("ee_pc", 64'(bus.excp_out.pc), 64'h1c00_0100);
    check("ee_ready_pend", 64'(bus.in_ready), 64'd0);
    tick();
    check("ee_excp_done", 64'(bus.excp_out_valid), 64'd0);
    check("ee_ready_post", 64'(bus.in_ready), 64'd1);
    check("ee_pulses", 64'(excp_pulses), 64'd1);

    // Overflow: offer while in_ready is low
    seen.delete();
    for (int k = 0; k < 4; k++) begin
      drive(3'b111, 64'h3000 + 64'(3 * k));
      tick();
    end
    check("ov_ready_low", 64'(bus.in_ready), 64'd0);
    drive(3'b111, 64'hDEAD0);
    tick();
    idle();
    check("ov_set", 64'(bus.overflow), 64'd1);
    check("ov_ready_back", 64'(bus.in_ready), 64'd1);
    tick();
    tick();
    check("ov_seen_count", 64'(seen.size()), 64'd12);
    dead_found = 0;
    foreach (seen[k]) if (seen[k][63:4] == 60'hDEAD) dead_found++;
    check("ov_dropped", 64'(dead_found), 64'd0);
    repeat (3) tick();
    check("ov_sticky", 64'(bus.overflow), 64'd1);
    check("ov_commit_cnt", bus.commit_cnt, 64'd36);

    // Reset with 6 queued and an exception pending
    excp_pulses = 0;
    for (int k = 0; k < 3; k++) begin
      drive(3'b111, 64'h4000 + 64'(3 * k));
      tick();
    end
    drive(3'b111, 64'h4009);
    bus.excp_in_valid = 1'b1;
    tick();
    idle();
    check("rm_pend_ready", 64'(bus.in_ready), 64'd0);
    check("rm_pend_out", 64'(bus.out_valid), 64'd3);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rm_async");
    seen.delete();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (4) tick();
    check("rm_no_stale", 64'(seen.size()), 64'd0);
    check("rm_no_excp", 64'(excp_pulses), 64'd0);
    check_reset_outputs("rm_after");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
